// File: rtl/ok_dram_fifo_ctrl.sv
// 64x8 FIFO controller sequencing an external dual-port distributed RAM; flags, count, sticky errors.
// Optional OK_DRAM_FIFO_OREG_EN: rd_data from a registered output stage held by a 2-state FSM.
module ok_dram_fifo_ctrl #(
  parameter int AFULL_THRESH  = 56,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       almost_full,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       almost_empty,
  output logic [6:0] count,
  output logic       overflow,
  output logic       underflow,
  output logic       ram_we,
  output logic [5:0] ram_addr_a,
  output logic [5:0] ram_addr_b,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout_b
);

  localparam logic [6:0] AF_T = 7'(AFULL_THRESH);
  localparam logic [6:0] AE_T = 7'(AEMPTY_THRESH);

  logic [6:0] wptr, rptr;
  logic [6:0] ram_cnt;
  logic       wr_acc, rd_acc, rd_adv;

  // Pointer difference (mod 128, wrap bit included) is exactly the word count held in RAM.
  assign ram_cnt = wptr - rptr;

  assign full         = (count == 7'd64);
  assign almost_full  = (count >= AF_T);
  assign almost_empty = (count <= AE_T);

  // Inputs are ignored in the reset cycle so the RAM is not written while pointers clear.
  assign wr_acc = wr_en & ~full & ~reset;
  assign rd_acc = rd_en & ~empty & ~reset;

  assign ram_we     = wr_acc;
  assign ram_din    = wr_data;
  assign ram_addr_a = wptr[5:0];
  assign ram_addr_b = rptr[5:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr <= wptr + 7'(wr_acc);
      rptr <= rptr + 7'(rd_adv);
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

`ifdef OK_DRAM_FIFO_OREG_EN
  typedef enum logic {S_EMPTY = 1'b0, S_VALID = 1'b1} state_t;
  state_t     state, state_nxt;
  logic [7:0] oreg;
  logic       load;

  // count includes the word parked in the output register.
  assign count   = ram_cnt + 7'(state == S_VALID);
  assign empty   = (state == S_EMPTY);
  assign rd_data = oreg;
  assign rd_adv  = load;

  always_ff @(posedge clk) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (ram_cnt != 7'd0) state_nxt = S_VALID;
      S_VALID: if (rd_acc && ram_cnt == 7'd0) state_nxt = S_EMPTY;
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    load = 1'b0;
    case (state)
      S_EMPTY: load = (ram_cnt != 7'd0);
      S_VALID: load = rd_acc && (ram_cnt != 7'd0);
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)     oreg <= 8'h00;
    else if (load) oreg <= ram_dout_b;
  end
`else
  assign count   = ram_cnt;
  assign empty   = (ram_cnt == 7'd0);
  assign rd_data = ram_dout_b;
  assign rd_adv  = rd_acc;
`endif

endmodule

// File: tb/tb_ok_dram_fifo_ctrl.sv
// Bench for ok_dram_fifo_ctrl: directed tests plus random traffic against a queue-based model.
module tb_ok_dram_fifo_ctrl;
`ifdef OK_DRAM_FIFO_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset, wr_en, rd_en;
  logic [7:0] wr_data;
  logic       full, almost_full, empty, almost_empty, overflow, underflow, ram_we;
  logic [7:0] rd_data, ram_din, ram_dout_b;
  logic [6:0] count;
  logic [5:0] ram_addr_a, ram_addr_b;

  ok_dram_fifo_ctrl #(.AFULL_THRESH(56), .AEMPTY_THRESH(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow),
    .ram_we(ram_we), .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b), .ram_din(ram_din),
    .ram_dout_b(ram_dout_b)
  );

  always #5 clk = ~clk;

  // External 64x8 distributed RAM: sync write port A, async read port B.
  logic [7:0] mem [64];
  always @(posedge clk) if (ram_we) mem[ram_addr_a] <= ram_din;
  assign ram_dout_b = mem[ram_addr_b];

  // Reference model: queue of words tagged with the cycle they were written.
  typedef struct { logic [7:0] d; int wc; } ent_t;
  ent_t q[$];
  int   cyc, wcnt, checks, errors;
  bit   m_ovf, m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wcnt = 0; m_ovf = 0; m_udf = 0;
  endtask

  // One clock: drive, check against the model at negedge, advance the model at posedge.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit rst = 1'b0);
    int sz;
    bit fm, vis;
    wr_en = w; wr_data = d; rd_en = r; reset = rst;
    @(negedge clk);
    sz  = q.size();
    fm  = (sz == 64);
    vis = (sz > 0) && (cyc >= q[0].wc + LAT);
    chk("count", 32'(count), 32'(sz));
    chk("full", 32'(full), 32'(fm));
    chk("empty", 32'(empty), 32'(!vis));
    chk("almost_full", 32'(almost_full), 32'(sz >= 56));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= 8));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("ram_we", 32'(ram_we), 32'(w && !fm && !rst));
    chk("ram_addr_a", 32'(ram_addr_a), 32'(wcnt % 64));
    if (vis) chk("rd_data", 32'(rd_data), 32'(q[0].d));
    if (w && !fm && !rst) chk("ram_din", 32'(ram_din), 32'(d));
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (w && fm)  m_ovf = 1;
      if (r && !vis) m_udf = 1;
      if (r && vis) void'(q.pop_front());
      if (w && !fm) begin
        q.push_back('{d: d, wc: cyc});
        wcnt++;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;

    // Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_flags", 32'({overflow, underflow}), 0);

    // 1: fill, then overflow attempt
    for (int i = 0; i < 64; i++) step(1, 8'(i), 0);
    chk("t1_full", 32'(full), 1);
    chk("t1_count", 32'(count), 64);
    step(1, 8'hAA, 0);
    chk("t1_ovf", 32'(overflow), 1);
    chk("t1_count_hold", 32'(count), 64);

    // 2: drain in order, then underflow
    for (int i = 0; i < 64; i++) begin
      chk("t2_order", 32'(rd_data), 32'(i));
      step(0, 8'h00, 1);
    end
    chk("t2_empty", 32'(empty), 1);
    step(0, 8'h00, 1);
    chk("t2_udf", 32'(underflow), 1);
    chk("t2_count", 32'(count), 0);

    // 3: pointer wrap
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 40; i++) step(1, 8'(i + 7), 0);
    for (int i = 0; i < 40; i++) step(0, 8'h00, 1);
    for (int i = 0; i < 40; i++) step(1, 8'(8'h80 + i), 0);
    chk("t3_addr_wrapped", 32'(ram_addr_a), 32'(16));
    chk("t3_count", 32'(count), 40);
    for (int i = 0; i < 40; i++) step(0, 8'h00, 1);

    // 4: simultaneous read/write at count=10 and at full
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0);
    step(0, 8'h00, 0);
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 1);
    chk("t4_count10", 32'(count), 10);
    for (int i = 0; i < 54; i++) step(1, 8'($urandom), 0);
    step(0, 8'h00, 0);
    step(1, 8'h55, 1);
    chk("t4_count63", 32'(count), 63);
    chk("t4_ovf", 32'(overflow), 1);

    // 5: threshold edges
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0);
    chk("t5_ae_at8", 32'(almost_empty), 1);
    step(1, 8'($urandom), 0);
    chk("t5_ae_at9", 32'(almost_empty), 0);
    for (int i = 0; i < 46; i++) step(1, 8'($urandom), 0);
    chk("t5_af_at55", 32'(almost_full), 0);
    step(1, 8'($urandom), 0);
    chk("t5_af_at56", 32'(almost_full), 1);

    // 6: reset mid-transfer with both requests active
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 1);
    for (int i = 0; i < 30; i++) step(1, 8'($urandom), 0);
    step(1, 8'h11, 1, 1);
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_addr_a", 32'(ram_addr_a), 0);
    chk("t6_addr_b", 32'(ram_addr_b), 0);
    chk("t6_flags", 32'({overflow, underflow}), 0);

    // Latency of a single write into an empty FIFO
    step(1, 8'h5A, 0);
    chk("lat_n1_empty", 32'(empty), 32'(LAT != 1));
    step(0, 8'h00, 0);
    chk("lat_n2_empty", 32'(empty), 0);
    chk("lat_data", 32'(rd_data), 32'h5A);

    // Random traffic with varying bias toward fill or drain
    for (int p = 0; p < 3; p++) begin
      int pw;
      pw = (p == 0) ? 75 : (p == 1) ? 25 : 50;
      for (int i = 0; i < 200; i++)
        step($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < 100 - pw + 10,
             $urandom_range(199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
